// File: rtl/riscv_tag_trap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_tag_trap_ctrl_pkg                                              |
// | Shared types and cause-bit indices for the DIFT tag-trap controller. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_tag_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    TT_IDLE = 2'd0,
    TT_HALT = 2'd1,
    TT_TRAP = 2'd2
  } tag_trap_state_e;

  localparam int TAG_CAUSE_S1 = 0;
  localparam int TAG_CAUSE_S2 = 1;
  localparam int TAG_CAUSE_D  = 2;
  localparam int TAG_CAUSE_PC = 3;

  // Per-operand violation mask in {pc,d,s2,s1} order.
  function automatic logic [3:0] tag_viol_mask(
    input logic chk_s1, input logic tag_s1,
    input logic chk_s2, input logic tag_s2,
    input logic chk_d,  input logic tag_d,
    input logic chk_pc, input logic tag_pc
  );
    logic [3:0] m;
    m               = 4'b0000;
    m[TAG_CAUSE_S1] = chk_s1 & tag_s1;
    m[TAG_CAUSE_S2] = chk_s2 & tag_s2;
    m[TAG_CAUSE_D]  = chk_d  & tag_d;
    m[TAG_CAUSE_PC] = chk_pc & tag_pc;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_tag_trap_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_sat_counter                                                    |
// | Saturating up-counter with synchronous clear (clear has priority).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module riscv_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && (r_value != {WIDTH{1'b1}})) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/riscv_tag_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_tag_trap_ctrl                                                  |
// | Kills, drains and traps on DIFT tag-check violations in EX.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module riscv_tag_trap_ctrl
  import riscv_tag_trap_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 ex_valid_i,
  input  logic                 check_s1_i,
  input  logic                 check_s2_i,
  input  logic                 check_d_i,
  input  logic                 check_pc_i,
  input  logic                 tag_s1_i,
  input  logic                 tag_s2_i,
  input  logic                 tag_d_i,
  input  logic                 tag_pc_i,
  input  logic [31:0]          ex_pc_i,
  input  logic [31:0]          ex_instr_i,
  input  logic                 trap_ack_i,
  input  logic                 clr_cnt_i,
  output logic                 kill_o,
  output logic                 halt_o,
  output logic                 trap_req_o,
  output logic [3:0]           cause_o,
  output logic [31:0]          epc_o,
  output logic [31:0]          einstr_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o
);

  localparam logic [3:0] c_drain_load = 4'(DRAIN_CYCLES - 1);

  tag_trap_state_e r_state;
  tag_trap_state_e w_next_state;
  logic [3:0]      r_drain;
  logic [3:0]      r_cause;
  logic [31:0]     r_epc;
  logic [31:0]     r_einstr;
  logic [3:0]      w_viol_mask;
  logic            w_viol;
  logic            w_accept;

  assign w_viol_mask = tag_viol_mask(check_s1_i, tag_s1_i, check_s2_i, tag_s2_i,
                                     check_d_i, tag_d_i, check_pc_i, tag_pc_i);
  assign w_viol      = ex_valid_i & enable_i & (|w_viol_mask);
  // Violations only count when the controller is free to respond.
  assign w_accept    = (r_state == TT_IDLE) & w_viol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TT_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      TT_IDLE: if (w_viol) w_next_state = TT_HALT;
      TT_HALT: if (r_drain == 4'd0) w_next_state = TT_TRAP;
      TT_TRAP: if (trap_ack_i) w_next_state = TT_IDLE;
      default: w_next_state = TT_IDLE;
    endcase
  end

  always_comb begin
    kill_o     = w_accept;
    halt_o     = (r_state == TT_HALT) || (r_state == TT_TRAP);
    trap_req_o = (r_state == TT_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain  <= 4'd0;
      r_cause  <= 4'd0;
      r_epc    <= 32'd0;
      r_einstr <= 32'd0;
    end else if (w_accept) begin
      r_drain  <= c_drain_load;
      r_cause  <= w_viol_mask;
      r_epc    <= ex_pc_i;
      r_einstr <= ex_instr_i;
    end else if ((r_state == TT_HALT) && (r_drain != 4'd0)) begin
      r_drain  <= r_drain - 4'd1;
    end
  end

  assign cause_o  = r_cause;
  assign epc_o    = r_epc;
  assign einstr_o = r_einstr;

  riscv_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_viol_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_accept),
    .clr   (clr_cnt_i),
    .value (viol_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_riscv_tag_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_tag_trap_ctrl                                               |
// | Directed scoreboard bench for the tag-trap controller.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_riscv_tag_trap_ctrl;

  typedef struct packed {
    logic        kill;
    logic        halt;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i, ex_valid_i;
  logic        check_s1_i, check_s2_i, check_d_i, check_pc_i;
  logic        tag_s1_i, tag_s2_i, tag_d_i, tag_pc_i;
  logic [31:0] ex_pc_i, ex_instr_i;
  logic        trap_ack_i, clr_cnt_i;
  logic        kill_o, halt_o, trap_req_o;
  logic [3:0]  cause_o;
  logic [31:0] epc_o, einstr_o;
  logic [1:0]  viol_cnt_o;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  e_cause;
  logic [31:0] e_epc, e_ein;
  logic [1:0]  e_cnt;

  always #5 clk = ~clk;

  riscv_tag_trap_ctrl #(
    .DRAIN_CYCLES (2),
    .CNT_WIDTH    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .ex_valid_i (ex_valid_i),
    .check_s1_i (check_s1_i),
    .check_s2_i (check_s2_i),
    .check_d_i  (check_d_i),
    .check_pc_i (check_pc_i),
    .tag_s1_i   (tag_s1_i),
    .tag_s2_i   (tag_s2_i),
    .tag_d_i    (tag_d_i),
    .tag_pc_i   (tag_pc_i),
    .ex_pc_i    (ex_pc_i),
    .ex_instr_i (ex_instr_i),
    .trap_ack_i (trap_ack_i),
    .clr_cnt_i  (clr_cnt_i),
    .kill_o     (kill_o),
    .halt_o     (halt_o),
    .trap_req_o (trap_req_o),
    .cause_o    (cause_o),
    .epc_o      (epc_o),
    .einstr_o   (einstr_o),
    .viol_cnt_o (viol_cnt_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: each negedge the DUT presents one cycle of outputs.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("kill",   {31'd0, kill_o},     {31'd0, e.kill});
      check("halt",   {31'd0, halt_o},     {31'd0, e.halt});
      check("trap",   {31'd0, trap_req_o}, {31'd0, e.trap});
      check("cause",  {28'd0, cause_o},    {28'd0, e.cause});
      check("epc",    epc_o,               e.epc);
      check("einstr", einstr_o,            e.ein);
      check("cnt",    {30'd0, viol_cnt_o}, {30'd0, e.cnt});
    end
  end

  // chk/tag bit order is {pc,d,s2,s1}.
  task automatic step(input logic r, input logic en, input logic vld,
                      input logic [3:0] chk, input logic [3:0] tag,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic ack, input logic clr,
                      input logic ek, input logic eh, input logic et);
    @(posedge clk);
    #1;
    rst        = r;
    enable_i   = en;
    ex_valid_i = vld;
    {check_pc_i, check_d_i, check_s2_i, check_s1_i} = chk;
    {tag_pc_i, tag_d_i, tag_s2_i, tag_s1_i}         = tag;
    ex_pc_i    = pc;
    ex_instr_i = ins;
    trap_ack_i = ack;
    clr_cnt_i  = clr;
    exp_q.push_back('{ek, eh, et, e_cause, e_epc, e_ein, e_cnt});
  endtask

  task automatic idl(input logic en, input logic ack, input logic eh, input logic et);
    step(1'b0, en, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, ack, 1'b0, 1'b0, eh, et);
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b0; ex_valid_i = 1'b0;
    {check_pc_i, check_d_i, check_s2_i, check_s1_i} = 4'h0;
    {tag_pc_i, tag_d_i, tag_s2_i, tag_s1_i}         = 4'h0;
    ex_pc_i = 32'h0; ex_instr_i = 32'h0; trap_ack_i = 1'b0; clr_cnt_i = 1'b0;
    e_cause = 4'h0; e_epc = 32'h0; e_ein = 32'h0; e_cnt = 2'd0;
    repeat (3) @(posedge clk);

    // Reset state and idle
    repeat (3) idl(1'b1, 1'b0, 1'b0, 1'b0);

    // Single s1 violation, busy violations ignored, 5 TRAP cycles before ack
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001, 32'h100, 32'h0020_8033, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_cause = 4'b0001; e_epc = 32'h100; e_ein = 32'h0020_8033; e_cnt = 2'd1;
    step(1'b0, 1'b1, 1'b1, 4'b0100, 4'b0100, 32'h200, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0100, 4'b0100, 32'h200, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0100, 4'b0100, 32'h200, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) idl(1'b1, 1'b0, 1'b1, 1'b1);
    idl(1'b1, 1'b1, 1'b1, 1'b1);
    idl(1'b1, 1'b0, 1'b0, 1'b0);
    idl(1'b1, 1'b1, 1'b0, 1'b0);

    // Masked tags: unchecked s2 tag, global disable, no valid instruction
    step(1'b0, 1'b1, 1'b1, 4'b1101, 4'b0010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idl(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'hf, 4'hf, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idl(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'hf, 4'hf, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idl(1'b1, 1'b0, 1'b0, 1'b0);

    // d violation, enable dropped during HALT, earliest ack, back-to-back pc violation
    step(1'b0, 1'b1, 1'b1, 4'b1100, 4'b0110, 32'h300, 32'h0011_2233, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_cause = 4'b0100; e_epc = 32'h300; e_ein = 32'h0011_2233; e_cnt = 2'd2;
    idl(1'b0, 1'b0, 1'b1, 1'b0);
    idl(1'b0, 1'b0, 1'b1, 1'b0);
    idl(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 4'b1000, 4'b1000, 32'h400, 32'h4455_6677, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_cause = 4'b1000; e_epc = 32'h400; e_ein = 32'h4455_6677; e_cnt = 2'd3;
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b1, 1'b1, 1'b1);
    idl(1'b1, 1'b0, 1'b0, 1'b0);

    // Fourth violation: counter saturates at 3
    step(1'b0, 1'b1, 1'b1, 4'hf, 4'hf, 32'h500, 32'h8899_0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_cause = 4'hf; e_epc = 32'h500; e_ein = 32'h8899_0011; e_cnt = 2'd3;
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b1, 1'b1, 1'b1);
    idl(1'b1, 1'b0, 1'b0, 1'b0);

    // Fifth violation with clear: clear wins; then reset during TRAP
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001, 32'h600, 32'h0a0b_0c0d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_cause = 4'b0001; e_epc = 32'h600; e_ein = 32'h0a0b_0c0d; e_cnt = 2'd0;
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    e_cause = 4'h0; e_epc = 32'h0; e_ein = 32'h0; e_cnt = 2'd0;
    step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010, 32'h700, 32'hcafe_f00d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_cause = 4'b0010; e_epc = 32'h700; e_ein = 32'hcafe_f00d; e_cnt = 2'd1;
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b0, 1'b1, 1'b0);
    idl(1'b1, 1'b1, 1'b1, 1'b1);
    idl(1'b1, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_tag_trap_ctrl.md
# riscv_tag_trap_ctrl

Sequences the response to DIFT tag-check violations in RI5CY. It combines the per-instruction check enables from the check decoder with operand and PC tags in EX. On a violation it kills the offending instruction, halts the pipeline for a drain period, then raises a tag trap to the controller with a request/acknowledge handshake. It also records cause, PC and instruction, and keeps a saturating violation count readable through the CSRs.

## Interface
- DRAIN_CYCLES, 2: cycles spent in HALT before the trap request; legal range 1..15.
- CNT_WIDTH, 16: width of the violation counter.

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- enable_i  in  1  global tag-trap enable from CSR
- ex_valid_i  in  1  valid instruction in EX this cycle
- check_s1_i / check_s2_i / check_d_i  in  1 each  check enables for rs1, rs2 and rd
- check_pc_i  in  1  PC tag check enable (execute-PC policy)
- tag_s1_i / tag_s2_i / tag_d_i / tag_pc_i  in  1 each  tags of rs1, rs2, old rd value and PC
- ex_pc_i  in  32  PC of EX instruction
- ex_instr_i  in  32  instruction word in EX
- trap_ack_i  in  1  controller accepted the trap
- clr_cnt_i  in  1  CSR write clearing the counter
- kill_o  out  1  suppress writeback/memory side effects of EX instruction (combinational)
- halt_o  out  1  stall IF/ID/EX
- trap_req_o  out  1  tag trap request
- cause_o  out  4  latched violation mask {pc,d,s2,s1}
- epc_o  out  32  latched violating PC
- einstr_o  out  32  latched violating instruction
- viol_cnt_o  out  CNT_WIDTH  saturating violation count

## Operation
- Violation: viol = ex_valid_i & enable_i & |{check_pc_i&tag_pc_i, check_d_i&tag_d_i, check_s2_i&tag_s2_i, check_s1_i&tag_s1_i}.
- FSM states are IDLE, HALT and TRAP.
- IDLE, viol=1: kill_o=1 in the same cycle. Latch cause_o, epc_o and einstr_o, load the drain counter with DRAIN_CYCLES-1, go to HALT, and increment viol_cnt_o.
- HALT: halt_o=1. Decrement the drain counter each cycle. Move to TRAP on the cycle the counter is 0.
- TRAP: halt_o=1 and trap_req_o=1, held until trap_ack_i=1. Return to IDLE the following cycle.
- Events outside IDLE:
  - viol is ignored in HALT and TRAP: no kill, no latch, no count.
  - trap_ack_i is ignored outside TRAP.
- Counter:
  - Saturates at all-ones.
  - clr_cnt_i wins over a simultaneous increment, giving 0.
- Latched cause/epc/einstr persist until the next accepted violation.
- enable_i deasserted in HALT or TRAP does not abort the sequence.

## Timing
- Reset values: state IDLE; kill_o, halt_o and trap_req_o 0; cause_o 0; epc_o and einstr_o 0; viol_cnt_o 0. A reset mid-sequence returns to IDLE next cycle with all of these reset values.
- kill_o is combinational in the violation cycle N. All other outputs are registered.
- Sequence from a violation in cycle N:
  - halt_o rises at N+1.
  - trap_req_o rises at N+1+DRAIN_CYCLES.
- Trap handshake:
  - An ack in cycle M (while in TRAP) drops halt_o and trap_req_o at M+1.
  - The earliest ack (same cycle trap_req_o rises) gives halt_o high for DRAIN_CYCLES+1 cycles.
  - A new violation is accepted from M+1.
- viol_cnt_o updates at N+1.

## Structure
- Additions to riscv_defines:
  - tag_trap_state_e enum {TT_IDLE, TT_HALT, TT_TRAP}.
  - Cause bit indices TAG_CAUSE_S1=0, TAG_CAUSE_S2=1, TAG_CAUSE_D=2, TAG_CAUSE_PC=3.
- One natural sub-module is riscv_sat_counter (parameter WIDTH; inc, clr, value), reusable for other CSR counters. The FSM, drain counter and capture registers stay in this block.

## Test plan
- Single violation:
  - Stimulus: enable=1, DRAIN_CYCLES=2, in cycle 10 ex_valid=1, check_s1=1, tag_s1=1, pc=0x0000_0100, instr=0x0020_8033.
  - Response: kill_o=1 in cycle 10 only; halt_o 1 in cycles 11–13+; trap_req_o from cycle 13; cause_o=4'b0001, epc_o=0x100, einstr_o=0x0020_8033, viol_cnt_o=1 from cycle 11.
- Ack handling:
  - Stimulus: trap_ack_i held 0 for 5 cycles of TRAP, then 1 in cycle 18.
  - Response: trap_req_o stays high through cycle 18; halt_o=0 and trap_req_o=0 at cycle 19; an ack at cycle 20 has no effect.
- Masked tag:
  - Stimulus: tag_s2=1 with check_s2=0; separately enable_i=0 with all checks and tags set.
  - Response: no kill, halt or count.
- Violation while busy:
  - Stimulus: second violation (cause d) asserted during HALT.
  - Response: cause_o remains 4'b0001, viol_cnt_o stays 1.
- Counter rules:
  - Stimulus: CNT_WIDTH=2, 4 violations.
  - Response: count sticks at 3. Then clr_cnt_i coinciding with a 5th violation gives count 0.
- Reset mid-sequence:
  - Stimulus: rst=1 during TRAP.
  - Response: next cycle IDLE, all outputs 0, and a violation in the cycle after rst deasserts is accepted normally.
